// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if
// Request/response bundle between the I/D requesters, memory and mem_arbiter.
// Revision: 1.0
// ============================================================================
interface mem_arbiter_if;
  logic        icache_req_valid;
  logic [63:0] icache_req_addr;
  logic        icache_req_ack;
  logic [3:0]  icache_req_tag;

  logic        dcache_req_valid;
  logic [1:0]  dcache_req_command;
  logic [63:0] dcache_req_addr;
  logic [63:0] dcache_req_data;
  logic        dcache_req_ack;
  logic [3:0]  dcache_req_tag;

  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  logic        icache_rd_valid;
  logic        dcache_rd_valid;
  logic [63:0] rd_data;
  logic [3:0]  rd_tag;
  logic [4:0]  outstanding_cnt;
  logic        tag_err;

  // slave is the arbiter; master is the environment (requesters and memory).
  modport slave (
    input  icache_req_valid, icache_req_addr,
    output icache_req_ack, icache_req_tag,
    input  dcache_req_valid, dcache_req_command, dcache_req_addr, dcache_req_data,
    output dcache_req_ack, dcache_req_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output icache_rd_valid, dcache_rd_valid, rd_data, rd_tag,
    output outstanding_cnt, tag_err
  );

  modport master (
    output icache_req_valid, icache_req_addr,
    input  icache_req_ack, icache_req_tag,
    output dcache_req_valid, dcache_req_command, dcache_req_addr, dcache_req_data,
    input  dcache_req_ack, dcache_req_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  icache_rd_valid, dcache_rd_valid, rd_data, rd_tag,
    input  outstanding_cnt, tag_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
// Two-requester memory arbiter with starvation guard and tag owner table.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] c_BUS_NONE  = 2'd0;
  localparam logic [1:0] c_BUS_LOAD  = 2'd1;
  localparam int         c_SW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [c_SW-1:0] starve_q, starve_d;
  logic [15:0]     valid_q, valid_d;
  logic [15:0]     owner_q, owner_d;     // 1 = D owns the tag
  logic            tag_err_q, tag_err_d;

  logic       grant_i, grant_d, both;
  logic       resp_nz, ack_i, ack_d, load_acc;
  logic       ret_hit, ret_miss, acc_clash;
  logic [4:0] cnt;

  // Grant: a held requester keeps the bus while valid, otherwise arbitrate.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    both    = bus.icache_req_valid && bus.dcache_req_valid;
    if (!reset) begin
      if (state_q == HOLD_I && bus.icache_req_valid) begin
        grant_i = 1'b1;
      end else if (state_q == HOLD_D && bus.dcache_req_valid) begin
        grant_d = 1'b1;
      end else if (both) begin
        if (starve_q == c_LIMIT) grant_i = 1'b1;
        else                     grant_d = 1'b1;
      end else begin
        grant_i = bus.icache_req_valid;
        grant_d = bus.dcache_req_valid;
      end
    end
  end

  assign resp_nz  = (bus.mem2proc_response != 4'd0);
  assign ack_i    = grant_i && resp_nz;
  assign ack_d    = grant_d && resp_nz;
  assign load_acc = ack_i || (ack_d && bus.dcache_req_command == c_BUS_LOAD);

  assign ret_hit   = !reset && (bus.mem2proc_tag != 4'd0) &&  valid_q[bus.mem2proc_tag];
  assign ret_miss  = !reset && (bus.mem2proc_tag != 4'd0) && !valid_q[bus.mem2proc_tag];
  assign acc_clash = load_acc && valid_q[bus.mem2proc_response] &&
                     !(ret_hit && bus.mem2proc_tag == bus.mem2proc_response);

  always_comb begin
    state_d   = IDLE;
    starve_d  = starve_q;
    valid_d   = valid_q;
    owner_d   = owner_q;
    tag_err_d = tag_err_q | ret_miss | acc_clash;

    if ((grant_i || grant_d) && !resp_nz) begin
      state_d = grant_i ? HOLD_I : HOLD_D;
    end

    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d && bus.icache_req_valid && starve_q != c_LIMIT) begin
      starve_d = starve_q + c_SW'(1);
    end

    // Clear the returning entry before setting the accepted one so a same-tag
    // return/accept leaves the entry valid with the new owner.
    if (ret_hit) begin
      valid_d[bus.mem2proc_tag] = 1'b0;
    end
    if (load_acc) begin
      valid_d[bus.mem2proc_response] = 1'b1;
      owner_d[bus.mem2proc_response] = ack_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      valid_q   <= '0;
      owner_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      valid_q   <= valid_d;
      owner_q   <= owner_d;
      tag_err_q <= tag_err_d;
    end
  end

  always_comb begin
    cnt = 5'd0;
    for (int k = 1; k < 16; k++) begin
      cnt = cnt + {4'd0, valid_q[k]};
    end
  end

  assign bus.proc2mem_command = grant_i ? c_BUS_LOAD :
                                grant_d ? bus.dcache_req_command : c_BUS_NONE;
  assign bus.proc2mem_addr    = grant_i ? bus.icache_req_addr :
                                grant_d ? bus.dcache_req_addr : 64'd0;
  assign bus.proc2mem_data    = grant_d ? bus.dcache_req_data : 64'd0;

  assign bus.icache_req_ack   = ack_i;
  assign bus.dcache_req_ack   = ack_d;
  assign bus.icache_req_tag   = ack_i ? bus.mem2proc_response : 4'd0;
  assign bus.dcache_req_tag   = ack_d ? bus.mem2proc_response : 4'd0;

  assign bus.icache_rd_valid  = ret_hit && !owner_q[bus.mem2proc_tag];
  assign bus.dcache_rd_valid  = ret_hit &&  owner_q[bus.mem2proc_tag];
  assign bus.rd_data          = bus.mem2proc_data;
  assign bus.rd_tag           = bus.mem2proc_tag;

  assign bus.outstanding_cnt  = reset ? 5'd0 : cnt;
  assign bus.tag_err          = tag_err_q && !reset;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT = 4).
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.icache_req_valid   = 1'b0;
    bus.icache_req_addr    = 64'd0;
    bus.dcache_req_valid   = 1'b0;
    bus.dcache_req_command = 2'd0;
    bus.dcache_req_addr    = 64'd0;
    bus.dcache_req_data    = 64'd0;
    bus.mem2proc_response  = 4'd0;
    bus.mem2proc_data      = 64'd0;
    bus.mem2proc_tag       = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: a valid, acceptable request must stay blocked
    clr();
    rst = 1'b1;
    bus.icache_req_valid  = 1'b1;
    bus.icache_req_addr   = 64'h1000;
    bus.mem2proc_response = 4'd3;
    tick();
    chk("rst_cmd",  bus.proc2mem_command, 2'd0);
    chk("rst_iack", bus.icache_req_ack, 1'b0);
    chk("rst_dack", bus.dcache_req_ack, 1'b0);
    chk("rst_cnt",  bus.outstanding_cnt, 5'd0);
    chk("rst_err",  bus.tag_err, 1'b0);
    tick();
    rst = 1'b0;
    clr();

    // Single I load, tag 3, then its return
    bus.icache_req_valid  = 1'b1;
    bus.icache_req_addr   = 64'h1000;
    bus.mem2proc_response = 4'd3;
    #1;
    chk("i_cmd",  bus.proc2mem_command, 2'd1);
    chk("i_addr", bus.proc2mem_addr, 64'h1000);
    chk("i_data", bus.proc2mem_data, 64'd0);
    chk("i_ack",  bus.icache_req_ack, 1'b1);
    chk("i_tag",  bus.icache_req_tag, 4'd3);
    chk("i_dack", bus.dcache_req_ack, 1'b0);
    chk("i_cnt0", bus.outstanding_cnt, 5'd0);
    tick();
    clr();
    bus.icache_req_addr = 64'h1234;
    #1;
    chk("i_cnt1",    bus.outstanding_cnt, 5'd1);
    chk("idle_cmd",  bus.proc2mem_command, 2'd0);
    chk("idle_addr", bus.proc2mem_addr, 64'd0);
    bus.mem2proc_tag  = 4'd3;
    bus.mem2proc_data = 64'hDEAD_BEEF;
    #1;
    chk("ret3_irv",  bus.icache_rd_valid, 1'b1);
    chk("ret3_drv",  bus.dcache_rd_valid, 1'b0);
    chk("ret3_data", bus.rd_data, 64'hDEAD_BEEF);
    chk("ret3_tag",  bus.rd_tag, 4'd3);
    tick();
    clr();
    #1;
    chk("ret3_cnt", bus.outstanding_cnt, 5'd0);
    chk("ret3_err", bus.tag_err, 1'b0);

    // Continuous contention, memory always accepts: D D D D I repeating
    bus.icache_req_valid   = 1'b1;
    bus.icache_req_addr    = 64'h2000;
    bus.dcache_req_valid   = 1'b1;
    bus.dcache_req_command = 2'd2;
    bus.dcache_req_addr    = 64'h3000;
    bus.dcache_req_data    = 64'h55;
    for (int k = 0; k < 10; k++) begin
      bus.mem2proc_response = 4'(k + 1);
      #1;
      chk($sformatf("starve_dack_%0d", k), bus.dcache_req_ack, (k % 5 != 4));
      chk($sformatf("starve_iack_%0d", k), bus.icache_req_ack, (k % 5 == 4));
      tick();
    end
    clr();
    #1;
    chk("starve_cnt", bus.outstanding_cnt, 5'd2);
    chk("starve_err", bus.tag_err, 1'b0);
    bus.mem2proc_tag = 4'd5;
    #1;
    chk("ret5_irv", bus.icache_rd_valid, 1'b1);
    tick();
    bus.mem2proc_tag = 4'd10;
    #1;
    chk("ret10_irv", bus.icache_rd_valid, 1'b1);
    tick();
    clr();
    #1;
    chk("starve_cnt0", bus.outstanding_cnt, 5'd0);

    // D store rejected while I waits; hold must win even once starve saturates
    bus.icache_req_valid   = 1'b1;
    bus.icache_req_addr    = 64'h5000;
    bus.dcache_req_valid   = 1'b1;
    bus.dcache_req_command = 2'd2;
    bus.dcache_req_addr    = 64'h4000;
    bus.dcache_req_data    = 64'hABCD;
    bus.mem2proc_response  = 4'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("hold_cmd_%0d", k),  bus.proc2mem_command, 2'd2);
      chk($sformatf("hold_addr_%0d", k), bus.proc2mem_addr, 64'h4000);
      chk($sformatf("hold_data_%0d", k), bus.proc2mem_data, 64'hABCD);
      chk($sformatf("hold_dack_%0d", k), bus.dcache_req_ack, 1'b0);
      chk($sformatf("hold_iack_%0d", k), bus.icache_req_ack, 1'b0);
      tick();
    end
    bus.mem2proc_response = 4'd4;
    #1;
    chk("hold_acc_dack", bus.dcache_req_ack, 1'b1);
    chk("hold_acc_dtag", bus.dcache_req_tag, 4'd4);
    chk("hold_acc_iack", bus.icache_req_ack, 1'b0);
    tick();

    // I alone rejected -> HOLD_I; then I drops and D is arbitrated same cycle
    bus.dcache_req_valid  = 1'b0;
    bus.mem2proc_response = 4'd0;
    #1;
    chk("store_cnt", bus.outstanding_cnt, 5'd0);
    chk("irej_cmd",  bus.proc2mem_command, 2'd1);
    chk("irej_addr", bus.proc2mem_addr, 64'h5000);
    chk("irej_iack", bus.icache_req_ack, 1'b0);
    tick();
    bus.icache_req_valid   = 1'b0;
    bus.dcache_req_valid   = 1'b1;
    bus.dcache_req_command = 2'd1;
    bus.dcache_req_addr    = 64'h7000;
    bus.mem2proc_response  = 4'd5;
    #1;
    chk("drop_cmd",  bus.proc2mem_command, 2'd1);
    chk("drop_addr", bus.proc2mem_addr, 64'h7000);
    chk("drop_dack", bus.dcache_req_ack, 1'b1);
    chk("drop_dtag", bus.dcache_req_tag, 4'd5);
    tick();
    clr();
    #1;
    chk("d5_cnt", bus.outstanding_cnt, 5'd1);

    // Same-tag return (D) and new accept (I) in one cycle
    bus.icache_req_valid  = 1'b1;
    bus.icache_req_addr   = 64'h6000;
    bus.mem2proc_response = 4'd5;
    bus.mem2proc_tag      = 4'd5;
    bus.mem2proc_data     = 64'h77;
    #1;
    chk("same_drv",  bus.dcache_rd_valid, 1'b1);
    chk("same_irv",  bus.icache_rd_valid, 1'b0);
    chk("same_iack", bus.icache_req_ack, 1'b1);
    chk("same_itag", bus.icache_req_tag, 4'd5);
    tick();
    clr();
    #1;
    chk("same_cnt", bus.outstanding_cnt, 5'd1);
    chk("same_err", bus.tag_err, 1'b0);
    bus.mem2proc_tag = 4'd5;
    #1;
    chk("newown_irv", bus.icache_rd_valid, 1'b1);
    chk("newown_drv", bus.dcache_rd_valid, 1'b0);
    tick();
    clr();
    #1;
    chk("newown_cnt", bus.outstanding_cnt, 5'd0);

    // Return to an invalid tag: dropped, sticky tag_err
    bus.mem2proc_tag  = 4'd9;
    bus.mem2proc_data = 64'h99;
    #1;
    chk("bad_irv", bus.icache_rd_valid, 1'b0);
    chk("bad_drv", bus.dcache_rd_valid, 1'b0);
    chk("bad_tag", bus.rd_tag, 4'd9);
    tick();
    clr();
    #1;
    chk("bad_err1", bus.tag_err, 1'b1);
    tick();
    chk("bad_err2", bus.tag_err, 1'b1);

    // Reset with three loads in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_err", bus.tag_err, 1'b0);
    bus.icache_req_valid  = 1'b1;
    bus.icache_req_addr   = 64'h8000;
    bus.mem2proc_response = 4'd1;
    #1;
    chk("l1_iack", bus.icache_req_ack, 1'b1);
    tick();
    clr();
    bus.dcache_req_valid   = 1'b1;
    bus.dcache_req_command = 2'd1;
    bus.dcache_req_addr    = 64'h9000;
    bus.mem2proc_response  = 4'd2;
    #1;
    chk("l2_dack", bus.dcache_req_ack, 1'b1);
    tick();
    clr();
    bus.icache_req_valid  = 1'b1;
    bus.icache_req_addr   = 64'hA000;
    bus.mem2proc_response = 4'd3;
    #1;
    chk("l3_iack", bus.icache_req_ack, 1'b1);
    tick();
    clr();
    #1;
    chk("l3_cnt", bus.outstanding_cnt, 5'd3);
    rst = 1'b1;
    bus.icache_req_valid  = 1'b1;
    bus.mem2proc_response = 4'd4;
    #1;
    chk("rst3_cmd",  bus.proc2mem_command, 2'd0);
    chk("rst3_iack", bus.icache_req_ack, 1'b0);
    tick();
    rst = 1'b0;
    clr();
    #1;
    chk("rst3_cnt", bus.outstanding_cnt, 5'd0);
    chk("rst3_cmd2", bus.proc2mem_command, 2'd0);
    bus.mem2proc_tag = 4'd2;
    #1;
    chk("stale_drv", bus.dcache_rd_valid, 1'b0);
    chk("stale_irv", bus.icache_rd_valid, 1'b0);
    tick();
    clr();
    #1;
    chk("stale_err", bus.tag_err, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive lost contended arbitrations after which the I-requester wins.
REQ-002 SHALL have one clock, `clock`; `reset` is synchronous and active-high.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- icache_req_valid  in  1  I-requester load request.
- icache_req_addr  in  64  I-requester line address.
- icache_req_ack  out  1  I-request accepted by memory this cycle.
- icache_req_tag  out  4  tag assigned to the accepted I-request.
- dcache_req_valid  in  1  D-requester (MSHR) request.
- dcache_req_command  in  2  BUS_LOAD=1 or BUS_STORE=2.
- dcache_req_addr  in  64  D-requester line address.
- dcache_req_data  in  64  store data.
- dcache_req_ack  out  1  D-request accepted this cycle.
- dcache_req_tag  out  4  tag assigned to the accepted D-request.
- proc2mem_command  out  2  memory command; BUS_NONE=0.
- proc2mem_addr  out  64  memory address.
- proc2mem_data  out  64  memory store data.
- mem2proc_response  in  4  nonzero = accepted with this tag; 0 = rejected.
- mem2proc_data  in  64  returned load data.
- mem2proc_tag  in  4  tag of returning data; 0 = none.
- icache_rd_valid  out  1  returned data belongs to I-requester.
- dcache_rd_valid  out  1  returned data belongs to D-requester.
- rd_data  out  64  mem2proc_data passthrough.
- rd_tag  out  4  mem2proc_tag passthrough.
- outstanding_cnt  out  5  number of loads in flight (0..15).
- tag_err  out  1  sticky flag: return for an unowned tag, or acceptance of an already-valid tag.

Function
REQ-004 SHALL have states IDLE, HOLD_I and HOLD_D; the grant is derived combinationally from the state and the request valids.
REQ-005 In IDLE, a sole valid requester SHALL be granted.
REQ-006 In IDLE with both requesters valid, D SHALL win unless starve_cnt == STARVE_LIMIT, in which case I SHALL win.
REQ-007 starve_cnt SHALL increment when I loses a contended grant, clear when I is granted, and saturate at STARVE_LIMIT.
REQ-008 The granted request SHALL drive proc2mem_* in the same cycle; I always issues BUS_LOAD with proc2mem_data = 0.
REQ-009 With no grant, proc2mem_command SHALL be BUS_NONE and proc2mem_addr/proc2mem_data SHALL be 0.
REQ-010 Accept SHALL mean grant && mem2proc_response != 0: the granted requester's ack = 1 and its req_tag = mem2proc_response, combinational, same cycle.
REQ-011 On accept, the next state SHALL be IDLE.
REQ-012 Reject (grant && mem2proc_response == 0) SHALL move the state to HOLD_I or HOLD_D, matching the granted requester.
REQ-013 In HOLD_x, requester x SHALL be granted unconditionally while its valid is high; the requester shall hold its addr, data and command stable.
REQ-014 In HOLD_x, if valid_x drops, the state SHALL return to IDLE and arbitration SHALL happen in that same cycle.
REQ-015 SHALL keep a 16-entry owner table (valid, owner I/D); entry 0 is never used.
REQ-016 An accepted BUS_LOAD SHALL set entry[mem2proc_response] valid with its owner on the next edge.
REQ-017 BUS_STORE accepts SHALL record nothing.
REQ-018 When mem2proc_tag != 0 and entry[mem2proc_tag] is valid, the block SHALL assert icache_rd_valid or dcache_rd_valid per owner, combinationally in the same cycle, and clear the entry on the next edge.
REQ-019 A return to an invalid entry SHALL drop the data (no rd_valid) and set tag_err.
REQ-020 An accept to an already-valid entry that is not being returned that cycle SHALL overwrite the entry and set tag_err.
REQ-021 When the same tag is returned and newly accepted in one cycle, the return SHALL route to the old owner first, and the entry SHALL end valid with the new owner.
REQ-022 outstanding_cnt SHALL change by +1 on a load accept, −1 on a valid return, and net 0 when both occur; it SHALL equal the popcount of valid entries.
REQ-023 rd_data and rd_tag SHALL always pass through mem2proc_data and mem2proc_tag.

Reset
REQ-024 While reset is high, the block SHALL be in IDLE with starve_cnt = 0, all table entries invalid, outstanding_cnt = 0 and tag_err = 0.
REQ-025 While reset is high, all request outputs SHALL be forced inactive: proc2mem_command = BUS_NONE and both acks = 0.
REQ-026 Reset asserted mid-operation SHALL discard in-flight tags; returns arriving after reset deasserts SHALL set tag_err.

Verification
REQ-027 Single I load at 0x1000, response = 3 -> icache_req_ack = 1 and icache_req_tag = 3; a later mem2proc_tag = 3 -> icache_rd_valid = 1 and outstanding_cnt goes 1 -> 0.
REQ-028 Both requesters valid every cycle, memory always accepts -> D granted 4 times, then I once, repeating.
REQ-029 D store rejected for 2 cycles while I is valid -> state HOLD_D, I not granted until the D accept in cycle 3.
REQ-030 Tag 5 is outstanding for D; in one cycle, return tag 5 and accept a new I load with response 5 -> dcache_rd_valid = 1, entry 5 owner becomes I, outstanding_cnt unchanged.
REQ-031 mem2proc_tag = 9 with entry 9 invalid -> no rd_valid, tag_err = 1 and sticky until reset.
REQ-032 Reset asserted with 3 loads outstanding -> next cycle outstanding_cnt = 0 and proc2mem_command = BUS_NONE.
